// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 8-bit binary to 3-digit BCD converter (shift-add-3)
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out
);

    typedef enum logic [1:0] {IDLE, ADJ, SHF, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [19:0] work;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign busy = (state == ADJ) || (state == SHF);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= {12'b0, bin_in};
                        cnt   <= '0;
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    work  <= {add3(work[19:16]), add3(work[15:12]), add3(work[11:8]), work[7:0]};
                    state <= SHF;
                end
                SHF: begin
                    work <= {work[18:0], 1'b0};
                    if (cnt == 3'd7) begin
                        // digits of the post-shift register sit one bit lower in the current one
                        bcd_out <= work[18:7];
                        state   <= DONE;
                    end else begin
                        cnt   <= cnt + 3'd1;
                        state <= ADJ;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int          checks = 0;
    int          passes = 0;
    logic [11:0] last_bcd;

    bin2bcd_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .bcd_out(bcd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered and left at a negedge; start is accepted at the first posedge (E0).
    task automatic do_conv(input logic [7:0] v, input bit keep_start, input logic [7:0] other);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        if (keep_start) begin
            start  = 1'b1;
            bin_in = other;
        end else begin
            start  = 1'b0;
            bin_in = 8'($urandom);
        end
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(k <= 16));
            chk("done", 32'(done), 32'(k == 17));
            if (k <= 16)
                chk("bcd_hold", 32'(bcd_out), 32'(last_bcd));
        end
        chk("bcd_result", 32'(bcd_out), 32'(model_bcd(int'(v))));
        last_bcd = model_bcd(int'(v));
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("bcd_after", 32'(bcd_out), 32'(last_bcd));
    endtask

    initial begin
        int done_seen;
        rst      = 1'b1;
        start    = 1'b1;
        bin_in   = 8'd55;
        last_bcd = 12'h000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'h000);
        rst = 1'b0;

        do_conv(8'd255, 1'b0, 8'd0);
        chk("bcd_255", 32'(bcd_out), 32'h255);

        do_conv(8'd0, 1'b0, 8'd0);
        chk("bcd_0", 32'(bcd_out), 32'h000);
        do_conv(8'd99, 1'b0, 8'd0);
        chk("bcd_99", 32'(bcd_out), 32'h099);

        for (int v = 0; v < 256; v++)
            do_conv(8'(v), 1'b0, 8'd0);

        do_conv(8'd128, 1'b1, 8'd7);
        chk("bcd_128", 32'(bcd_out), 32'h128);
        do_conv(8'd7, 1'b0, 8'd0);
        chk("bcd_7", 32'(bcd_out), 32'h007);

        // Reset in the middle of a conversion of 200
        start  = 1'b1;
        bin_in = 8'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_bcd", 32'(bcd_out), 32'h000);
        rst       = 1'b0;
        last_bcd  = 12'h000;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("no_done_after_rst", 32'(done_seen), 32'd0);
        do_conv(8'd200, 1'b0, 8'd0);
        chk("bcd_200", 32'(bcd_out), 32'h200);

        for (int i = 0; i < 10; i++)
            do_conv(8'($urandom_range(255, 0)), 1'b0, 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clocks or resets.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-005 The block SHALL have port bin_in, input, 8 bits: unsigned binary operand, captured on an accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in ADJ or SHF.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-008 The block SHALL have port bcd_out, output, 12 bits: {hundreds, tens, units}, each 4-bit BCD.

Function
REQ-009 The block SHALL convert bin_in to BCD by shift-add-3 (double dabble) over exactly 8 iterations.
REQ-010 Each iteration SHALL apply the add-3 correction cell to all three digit nibbles: a nibble >= 5 gets +3, modulo 16; a nibble <= 4 is unchanged.
REQ-011 The working register SHALL be 20 bits: {hund[3:0], tens[3:0], units[3:0], bin[7:0]}.
REQ-012 The block SHALL hold a 3-bit iteration counter, cnt, plus the 20-bit working register.
REQ-013 The FSM SHALL have four states: IDLE, ADJ, SHF, DONE.
REQ-014 IDLE with start=1 at an edge SHALL load the working register with {12'b0, bin_in}, clear cnt and enter ADJ; IDLE with start=0 SHALL stay in IDLE.
REQ-015 ADJ SHALL apply the correction to all three nibbles in one cycle, then enter SHF.
REQ-016 SHF SHALL shift the working register left by 1 with zero fill.
REQ-017 In SHF with cnt<7, the block SHALL increment cnt and return to ADJ.
REQ-018 In SHF with cnt==7, the block SHALL load bcd_out from the shifted register bits [19:8] and enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency: with start accepted at edge E0, busy SHALL be high in the cycles after E0 through E15.
REQ-021 Latency: with start accepted at edge E0, done SHALL be high only in the cycle after E16.
REQ-022 Latency: with start accepted at edge E0, bcd_out SHALL be valid from E16.
REQ-023 busy and done SHALL never be high in the same cycle.
REQ-024 start SHALL be ignored in ADJ, SHF and DONE; bin_in changes after acceptance SHALL not affect the running conversion.
REQ-025 A start asserted in DONE SHALL be ignored, and a new start SHALL be accepted in the following IDLE cycle.
REQ-026 The minimum start-to-start spacing SHALL therefore be 18 cycles.
REQ-027 bcd_out SHALL hold its last result until the next DONE entry and SHALL not change during a conversion.
REQ-028 The hundreds nibble SHALL never exceed 2 and the tens and units nibbles SHALL never exceed 9 for any 8-bit input; no overflow indication exists.
REQ-029 busy and done SHALL be decoded from registered state; bcd_out SHALL be a register.

Reset
REQ-030 rst=1 at an edge SHALL force the IDLE state, clear cnt and the working register, and set busy=0, done=0 and bcd_out=12'h000, overriding start in that cycle.
REQ-031 Reset during ADJ, SHF or DONE SHALL abort the conversion, produce no done pulse, and clear bcd_out.
REQ-032 The first start SHALL be accepted at the first edge with rst=0 and start=1.

Verification
REQ-033 The bench SHALL cover bin_in=8'd255, start pulsed: busy high for 16 cycles, then done high for 1 cycle and bcd_out=12'h255.
REQ-034 The bench SHALL cover bin_in=0 and bin_in=8'd99 in back-to-back conversions: bcd_out=12'h000 then 12'h099, each done exactly 17 cycles after its accepted start.
REQ-035 The bench SHALL cover an exhaustive sweep of 0..255: each bcd_out equals the decimal digits of the input; done is a single-cycle pulse each time; bcd_out is stable between done pulses.
REQ-036 The bench SHALL cover bin_in=8'd128 accepted, then start=1 with bin_in=8'd7 held through cycles 3..17: result bcd_out=12'h128, only one done pulse, and 8'd7 accepted at the first IDLE edge after done.
REQ-037 The bench SHALL cover rst=1 at cycle 9 of a conversion of 8'd200: next cycle busy=0, done=0 and bcd_out=12'h000, no done pulse afterward, and a subsequent start of 8'd200 gives 12'h200.
